// File: rtl/axis_stall_pkg.sv
// rtl/axis_stall_pkg.sv - shared types and helpers for the AXI-stream stall detector
package axis_stall_pkg;

    localparam int DEFAULT_STALL_THRESH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WATCH = 2'd1,
        ST_FLAG  = 2'd2
    } stall_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_stall_counter.sv
// rtl/axis_stall_counter.sv - per-channel saturating stall counter; optional max tracker (AXIS_STALL_MAX_TRACK_EN)
module axis_stall_counter
    import axis_stall_pkg::*;
#(
    parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
    localparam int CNT_W = $clog2(STALL_THRESH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             ch_valid,
    input  logic             ch_ready,
    input  logic             ch_wait,
    output logic             at_thresh
`ifdef AXIS_STALL_MAX_TRACK_EN
    ,
    output logic [CNT_W-1:0] max_stall
`endif
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

    logic [CNT_W-1:0] cnt;
    logic             xfer;

    assign xfer      = ch_valid & ch_ready;
    assign at_thresh = (cnt == THRESH_C);

    // A transfer or a dropped wait ends the stall run; otherwise count up and hold at threshold.
    always_ff @(posedge clock) begin
        if (reset || clear || xfer || !ch_wait) begin
            cnt <= '0;
        end else if (cnt != THRESH_C) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef AXIS_STALL_MAX_TRACK_EN
    // Only reset clears the high-water mark; idle and enable do not.
    always_ff @(posedge clock) begin
        if (reset) begin
            max_stall <= '0;
        end else if (cnt > max_stall) begin
            max_stall <= cnt;
        end
    end
`endif

endmodule

// File: rtl/axis_stall_detector.sv
// rtl/axis_stall_detector.sv - flags AXI-stream channels stalled past a threshold; AXIS_STALL_MAX_TRACK_EN adds max_stall
module axis_stall_detector
    import axis_stall_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
    localparam int CNT_W = $clog2(STALL_THRESH + 1),
    localparam int IDX_W = idx_width(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    inst_idle,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ready,
    input  logic [NUM_CH-1:0]       ch_wait,
    output logic [NUM_CH-1:0]       axis_block_sigs,
    output logic                    any_block,
    output logic                    first_block_vld,
    output logic [IDX_W-1:0]        first_block_idx
`ifdef AXIS_STALL_MAX_TRACK_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] max_stall
`endif
);

    stall_state_t      state;
    logic [NUM_CH-1:0] at_thresh;
    logic              cnt_clear;
    logic              any_at;
    logic [IDX_W-1:0]  low_idx;

    assign cnt_clear = inst_idle | ~enable | (state == ST_IDLE);
    assign any_at    = |at_thresh;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        axis_stall_counter #(
            .STALL_THRESH(STALL_THRESH)
        ) u_cnt (
            .clock    (clock),
            .reset    (reset),
            .clear    (cnt_clear),
            .ch_valid (ch_valid[i]),
            .ch_ready (ch_ready[i]),
            .ch_wait  (ch_wait[i]),
            .at_thresh(at_thresh[i])
`ifdef AXIS_STALL_MAX_TRACK_EN
            ,
            .max_stall(max_stall[i*CNT_W +: CNT_W])
`endif
        );
    end

    // Scan from the top down so the lowest flagged index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (at_thresh[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            state           <= ST_IDLE;
            axis_block_sigs <= '0;
            any_block       <= 1'b0;
            first_block_vld <= 1'b0;
            first_block_idx <= '0;
        end else begin
            axis_block_sigs <= at_thresh;
            any_block       <= any_at;
            case (state)
                ST_IDLE: begin
                    state <= ST_WATCH;
                end
                ST_WATCH: begin
                    if (any_at) begin
                        state           <= ST_FLAG;
                        first_block_vld <= 1'b1;
                        first_block_idx <= low_idx;
                    end
                end
                ST_FLAG: begin
                    if (!any_at) begin
                        state           <= ST_WATCH;
                        first_block_vld <= 1'b0;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    first_block_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stall_detector.sv
// tb/tb_axis_stall_detector.sv - scoreboard bench for axis_stall_detector; covers max_stall when AXIS_STALL_MAX_TRACK_EN is set
module tb_axis_stall_detector;

    localparam int NCH = 4;
    localparam int T   = 8;
    localparam int CW  = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic            inst_idle;
    logic [NCH-1:0]  ch_valid;
    logic [NCH-1:0]  ch_ready;
    logic [NCH-1:0]  ch_wait;
    logic [NCH-1:0]  axis_block_sigs;
    logic            any_block;
    logic            first_block_vld;
    logic [1:0]      first_block_idx;
`ifdef AXIS_STALL_MAX_TRACK_EN
    logic [NCH*CW-1:0] max_stall;
`endif

    always #5 clock = ~clock;

    axis_stall_detector #(
        .NUM_CH(NCH),
        .STALL_THRESH(T)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .inst_idle      (inst_idle),
        .ch_valid       (ch_valid),
        .ch_ready       (ch_ready),
        .ch_wait        (ch_wait),
        .axis_block_sigs(axis_block_sigs),
        .any_block      (any_block),
        .first_block_vld(first_block_vld),
        .first_block_idx(first_block_idx)
`ifdef AXIS_STALL_MAX_TRACK_EN
        ,
        .max_stall      (max_stall)
`endif
    );

    typedef struct {
        logic [NCH-1:0] block;
        logic           any;
        logic           vld;
        logic [1:0]     idx;
        logic [15:0]    maxv;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: stall run lengths as integers, detector mode as two flags.
    int m_run[NCH];
    int m_max[NCH];
    bit m_running;
    bit m_flagged;
    int m_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        bit   hit[NCH];
        bit   any_hit;
        int   low;
        any_hit = 0;
        low     = -1;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = (m_run[i] == T);
            if (hit[i]) begin
                any_hit = 1;
                if (low < 0) low = i;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (reset) m_max[i] = 0;
            else if (m_run[i] > m_max[i]) m_max[i] = m_run[i];
        end
        if (reset || !enable) begin
            for (int i = 0; i < NCH; i++) begin
                m_run[i] = 0;
                hit[i]   = 0;
            end
            any_hit   = 0;
            m_running = 0;
            m_flagged = 0;
            m_idx     = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (inst_idle || !m_running || (ch_valid[i] && ch_ready[i]) || !ch_wait[i])
                    m_run[i] = 0;
                else if (m_run[i] < T)
                    m_run[i] = m_run[i] + 1;
            end
            if (!m_running) begin
                m_running = 1;
            end else if (!m_flagged && any_hit) begin
                m_flagged = 1;
                m_idx     = low;
            end else if (m_flagged && !any_hit) begin
                m_flagged = 0;
            end
        end
        for (int i = 0; i < NCH; i++) e.block[i] = hit[i];
        e.any = any_hit;
        e.vld = m_flagged;
        e.idx = 2'(m_idx);
        e.maxv = '0;
        for (int i = 0; i < NCH; i++) e.maxv[i*CW +: CW] = CW'(m_max[i]);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_block", 32'(axis_block_sigs), 32'(e.block));
                chk("sb_any",   32'(any_block),       32'(e.any));
                chk("sb_vld",   32'(first_block_vld), 32'(e.vld));
                chk("sb_idx",   32'(first_block_idx), 32'(e.idx));
`ifdef AXIS_STALL_MAX_TRACK_EN
                chk("sb_max",   32'(max_stall),       32'(e.maxv));
`endif
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0;
            m_max[i] = 0;
        end
        m_running = 0;
        m_flagged = 0;
        m_idx     = 0;
        reset = 1'b1; enable = 1'b0; inst_idle = 1'b0;
        ch_valid = '0; ch_ready = '0; ch_wait = '0;
        cycle(2);
        chk("reset_block", 32'(axis_block_sigs), 32'h0);
        chk("reset_vld",   32'(first_block_vld), 32'h0);
        reset = 1'b0; enable = 1'b1;
        cycle(1);

        // Channel 1 stall: flag visible on the 9th cycle, not the 8th.
        ch_wait = 4'b0010;
        cycle(8);
        chk("ch1_pre_block", 32'(axis_block_sigs), 32'h0);
        cycle(1);
        chk("ch1_block", 32'(axis_block_sigs), 32'h2);
        chk("ch1_idx",   32'(first_block_idx), 32'h1);
        chk("ch1_vld",   32'(first_block_vld), 32'h1);
        chk("ch1_any",   32'(any_block),       32'h1);

        // Recovery via one handshake.
        ch_valid = 4'b0010; ch_ready = 4'b0010;
        cycle(1);
        ch_valid = '0; ch_ready = '0; ch_wait = '0;
        cycle(1);
        chk("rec_block", 32'(axis_block_sigs), 32'h0);
        chk("rec_vld",   32'(first_block_vld), 32'h0);
        cycle(1);

        // Tie between channels 2 and 3.
        ch_wait = 4'b1100;
        cycle(9);
        chk("tie_block", 32'(axis_block_sigs), 32'hC);
        chk("tie_idx",   32'(first_block_idx), 32'h2);
        ch_wait = '0;
        cycle(2);

        // Channel 0 first, channel 3 five cycles later.
        ch_wait = 4'b0001;
        cycle(5);
        ch_wait = 4'b1001;
        cycle(9);
        chk("late_block", 32'(axis_block_sigs), 32'h9);
        chk("late_idx",   32'(first_block_idx), 32'h0);
        ch_wait = '0;
        cycle(2);

        // Idle pulse restarts the run.
        ch_wait = 4'b0100;
        cycle(6);
        inst_idle = 1'b1;
        cycle(1);
        inst_idle = 1'b0;
        cycle(8);
        chk("idle_pre_block", 32'(axis_block_sigs), 32'h0);
        cycle(1);
        chk("idle_block", 32'(axis_block_sigs), 32'h4);

        // Enable drop while flagged.
        enable = 1'b0;
        cycle(1);
        chk("en_block", 32'(axis_block_sigs), 32'h0);
        chk("en_any",   32'(any_block),       32'h0);
        chk("en_vld",   32'(first_block_vld), 32'h0);
        chk("en_idx",   32'(first_block_idx), 32'h0);
        enable = 1'b1;
        ch_wait = 4'b0001;
        cycle(6);

        // Reset mid-stall, then a 5-cycle stall for the high-water mark.
        reset = 1'b1;
        cycle(1);
        chk("rst_block", 32'(axis_block_sigs), 32'h0);
        chk("rst_vld",   32'(first_block_vld), 32'h0);
        reset = 1'b0; ch_wait = '0;
        cycle(1);
        ch_wait = 4'b0001;
        cycle(5);
        ch_wait = '0;
        cycle(1);
        inst_idle = 1'b1;
        cycle(2);
        inst_idle = 1'b0;
`ifdef AXIS_STALL_MAX_TRACK_EN
        chk("max_slice0", 32'(max_stall[CW-1:0]), 32'd5);
`endif

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 149) == 0);
            enable    = ($urandom_range(0, 59) != 0);
            inst_idle = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NCH; i++) begin
                ch_wait[i]  = ($urandom_range(0, 9) != 0);
                ch_valid[i] = ($urandom_range(0, 3) == 0);
                ch_ready[i] = ($urandom_range(0, 3) == 0);
            end
            cycle(1);
        end

        reset = 1'b0; enable = 1'b1; inst_idle = 1'b0; ch_wait = '0;
        cycle(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
